// File: rtl/dma_copy_engine_if.sv
// Register-port and Wishbone-master signal bundle for dma_copy_engine.
// master = the engine side, slave = the CPU/arbiter side.
interface dma_copy_engine_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        dma_stb_o;
    logic        dma_cyc_o;
    logic        dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_dat_o;
    logic [31:0] dma_adr_o;
    logic        dma_ack_i;
    logic [31:0] dma_dat_i;
    logic        irq;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata,
        output dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_dat_o, dma_adr_o,
        input  dma_ack_i, dma_dat_i,
        output irq
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata,
        input  dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_dat_o, dma_adr_o,
        output dma_ack_i, dma_dat_i,
        input  irq
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy engine: reads up to BURST_LEN words into a local buffer,
// writes them back out, and repeats until LEN words have moved.
module dma_copy_engine #(
    parameter int BURST_LEN = 8,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dma_copy_engine_if.master    bus
);
    localparam int IW = $clog2(BURST_LEN);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_GAP = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [CW-1:0]     chunk_q, chunk_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              stb_q, stb_d, we_q, we_d, irq_q, irq_d;
    logic [31:0]       adr_q, adr_d, dat_q, dat_d;
    logic              buf_we_s;
    logic [31:0]       buf_mem [BURST_LEN];
    logic              unused_s;

    function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] rem);
        if (32'(rem) < 32'(BURST_LEN)) begin
            return CW'(rem);
        end else begin
            return CW'(BURST_LEN);
        end
    endfunction

    // Register port, sequencing FSM and the next values of the registered bus outputs.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        buf_we_s    = 1'b0;

        if (bus.cfg_we && !busy_q) begin
            case (bus.cfg_addr)
                2'd0: begin
                    if (bus.cfg_wdata[0]) begin
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        cur_src_d   = src_q;
                        cur_dst_d   = dst_q;
                        remaining_d = len_q;
                    end else begin
                        busy_d = busy_q;
                    end
                end
                2'd1:    src_d = {bus.cfg_wdata[31:2], 2'b00};
                2'd2:    dst_d = {bus.cfg_wdata[31:2], 2'b00};
                2'd3:    len_d = bus.cfg_wdata[LEN_W-1:0];
                default: len_d = len_q;
            endcase
        end else begin
            len_d = len_q;
        end

        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    if (remaining_q == '0) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                        chunk_d = chunk_of(remaining_q);
                        rcnt_d  = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (bus.dma_ack_i) begin
                    buf_we_s  = 1'b1;
                    rcnt_d    = rcnt_q + CW'(1);
                    cur_src_d = cur_src_q + 32'd4;
                    state_d   = S_RD_GAP;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_GAP: begin
                if (rcnt_q < chunk_q) begin
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_WR_REQ;
                    wcnt_d  = '0;
                end
            end
            S_WR_REQ: begin
                if (bus.dma_ack_i) begin
                    wcnt_d    = wcnt_q + CW'(1);
                    cur_dst_d = cur_dst_q + 32'd4;
                    state_d   = S_WR_GAP;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_GAP: begin
                if (wcnt_q < chunk_q) begin
                    state_d = S_WR_REQ;
                end else begin
                    remaining_d = remaining_q - LEN_W'(chunk_q);
                    rcnt_d      = '0;
                    if (remaining_d != '0) begin
                        state_d = S_RD_REQ;
                        chunk_d = chunk_of(remaining_d);
                    end else begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so they follow the state being entered.
        stb_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        we_d  = (state_d == S_WR_REQ);
        irq_d = (state_d == S_FIN);
        if (state_d == S_RD_REQ) begin
            adr_d = cur_src_d;
        end else if (state_d == S_WR_REQ) begin
            adr_d = cur_dst_d;
        end else begin
            adr_d = 32'h0;
        end
        if (we_d) begin
            dat_d = buf_mem[wcnt_d[IW-1:0]];
        end else begin
            dat_d = 32'h0;
        end
    end

    // State, configuration and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= 32'h0;
            dst_q       <= 32'h0;
            len_q       <= '0;
            cur_src_q   <= 32'h0;
            cur_dst_q   <= 32'h0;
            remaining_q <= '0;
            chunk_q     <= '0;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            irq_q       <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            irq_q       <= irq_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    // Chunk buffer; contents need no reset since every word is written before it is read.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[rcnt_q[IW-1:0]] <= bus.dma_dat_i;
        end
    end

    // Status/config readback.
    always_comb begin
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = {30'b0, done_q, busy_q};
            2'd1:    bus.cfg_rdata = src_q;
            2'd2:    bus.cfg_rdata = dst_q;
            2'd3:    bus.cfg_rdata = 32'(len_q);
            default: bus.cfg_rdata = 32'h0;
        endcase
    end

    assign bus.dma_stb_o = stb_q;
    assign bus.dma_cyc_o = stb_q;
    assign bus.dma_we_o  = we_q;
    assign bus.dma_sel_o = stb_q ? 4'hF : 4'h0;
    assign bus.dma_adr_o = adr_q;
    assign bus.dma_dat_o = dat_q;
    assign bus.irq       = irq_q;
    assign unused_s      = bus.cfg_wdata[1];
endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: a Wishbone slave model with programmable ack
// latency logs every beat, and each transfer is compared with a chunked-copy model.
module tb_dma_copy_engine;
    localparam int BL = 8;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          delay;
        int          exp_beats;
        logic [31:0] exp_last_wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    dma_copy_engine_if dif ();

    dma_copy_engine #(.BURST_LEN(BL), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    beat_t       log_q[$];
    logic [31:0] mem [logic [31:0]];
    int          passed, total;
    int          irq_cnt, gap_bad, unstable, sel_bad, beats_seen, ack_delay;
    int          idle_run, wcount;
    logic        waiting;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    time         irq_time, wr_time;
    vec_t        vecs[5];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        dif.cfg_we    = 1'b1;
        dif.cfg_addr  = a;
        dif.cfg_wdata = d;
        wr_time       = $time;
        @(negedge clk);
        dif.cfg_we    = 1'b0;
        dif.cfg_wdata = 32'h0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        dif.cfg_addr = a;
        #1;
        d = dif.cfg_rdata;
    endtask

    task automatic setup_and_start(input logic [31:0] s, input logic [31:0] d,
                                   input logic [15:0] l, input int dly);
        log_q.delete();
        mem.delete();
        irq_cnt    = 0;
        gap_bad    = 0;
        unstable   = 0;
        sel_bad    = 0;
        beats_seen = 0;
        ack_delay  = dly;
        cfg_write(2'd1, s);
        cfg_write(2'd2, d);
        cfg_write(2'd3, 32'(l));
        cfg_write(2'd0, 32'd1);
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n;
        n = 0;
        while (irq_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_irq_seen"}, 32'(irq_cnt > 0), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    // Expected bus trace: per chunk, all reads then all writes of the same words.
    task automatic check_transfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                                  input logic [15:0] l, input int exp_beats,
                                  input logic [31:0] exp_last_wr);
        beat_t       e[$];
        int          n, mism;
        logic [31:0] a, st, last_wr;
        for (int off = 0; off < int'(l); off += BL) begin
            n = (int'(l) - off < BL) ? int'(l) - off : BL;
            for (int i = 0; i < n; i++) begin
                a = s + 32'((off + i) * 4);
                e.push_back('{1'b0, a, pat(a)});
            end
            for (int i = 0; i < n; i++) begin
                a = s + 32'((off + i) * 4);
                e.push_back('{1'b1, d + 32'((off + i) * 4), pat(a)});
            end
        end
        mism    = (e.size() == log_q.size()) ? 0 : 1;
        last_wr = 32'h0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].we) last_wr = log_q[i].adr;
            if (i < e.size()) begin
                if (log_q[i].we !== e[i].we || log_q[i].adr !== e[i].adr ||
                    log_q[i].dat !== e[i].dat) mism++;
            end
        end
        check({tag, "_beats"}, 32'(log_q.size()), 32'(exp_beats));
        check({tag, "_seq_mismatches"}, 32'(mism), 32'd0);
        check({tag, "_last_wr_adr"}, last_wr, exp_last_wr);
        check({tag, "_irq_count"}, 32'(irq_cnt), 32'd1);
        check({tag, "_gap_errors"}, 32'(gap_bad), 32'd0);
        check({tag, "_unstable_beats"}, 32'(unstable), 32'd0);
        check({tag, "_sel_cyc_errors"}, 32'(sel_bad), 32'd0);
        cfg_read(2'd0, st);
        check({tag, "_status"}, st, 32'h2);
    endtask

    // Wishbone slave: ack after ack_delay wait cycles, log beats, police gaps and stability.
    initial begin : wb_slave
        beat_t b;
        dif.dma_ack_i = 1'b0;
        dif.dma_dat_i = 32'h0;
        waiting  = 1'b0;
        idle_run = 0;
        wcount   = 0;
        forever begin
            @(negedge clk);
            if (dif.irq) begin
                irq_cnt++;
                if (irq_cnt == 1) irq_time = $time;
            end
            dif.dma_ack_i = 1'b0;
            dif.dma_dat_i = 32'h0;
            if (rst) begin
                waiting  = 1'b0;
                idle_run = 0;
            end else if (!dif.dma_stb_o) begin
                idle_run++;
            end else begin
                if (dif.dma_sel_o !== 4'hF || dif.dma_cyc_o !== 1'b1) sel_bad++;
                if (!waiting) begin
                    if (beats_seen > 0 && idle_run != 1) gap_bad++;
                    waiting = 1'b1;
                    wcount  = 0;
                    cap_adr = dif.dma_adr_o;
                    cap_dat = dif.dma_dat_o;
                    cap_we  = dif.dma_we_o;
                end else if (cap_adr !== dif.dma_adr_o || cap_dat !== dif.dma_dat_o ||
                             cap_we !== dif.dma_we_o) begin
                    unstable++;
                end
                if (wcount >= ack_delay) begin
                    dif.dma_ack_i = 1'b1;
                    if (dif.dma_we_o) begin
                        mem[dif.dma_adr_o] = dif.dma_dat_o;
                        b = '{1'b1, dif.dma_adr_o, dif.dma_dat_o};
                    end else begin
                        dif.dma_dat_i = mem.exists(dif.dma_adr_o) ? mem[dif.dma_adr_o]
                                                                  : pat(dif.dma_adr_o);
                        b = '{1'b0, dif.dma_adr_o, dif.dma_dat_i};
                    end
                    log_q.push_back(b);
                    beats_seen++;
                    waiting  = 1'b0;
                    idle_run = 0;
                end else begin
                    wcount++;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        int          n;
        passed = 0;
        total  = 0;
        irq_cnt = 0;
        ack_delay = 0;
        beats_seen = 0;
        dif.cfg_we    = 1'b0;
        dif.cfg_addr  = 2'd0;
        dif.cfg_wdata = 32'h0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3,  0, 6,  32'h0000_0208};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd20, 0, 40, 32'h0000_204C};
        vecs[2] = '{32'h0000_0300, 32'h0000_0400, 16'd0,  0, 0,  32'h0000_0000};
        vecs[3] = '{32'h0000_0500, 32'h0000_0600, 16'd4,  5, 8,  32'h0000_060C};
        vecs[4] = '{32'h0000_07F0, 32'h0000_0900, 16'd9,  1, 18, 32'h0000_0920};

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(dif.dma_stb_o), 32'd0);
        check("rst_cyc", 32'(dif.dma_cyc_o), 32'd0);
        check("rst_irq", 32'(dif.irq), 32'd0);
        check("rst_adr", dif.dma_adr_o, 32'h0);
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Register port: low address bits forced to zero.
        cfg_write(2'd1, 32'h0000_0103);
        cfg_write(2'd2, 32'hABCD_EF07);
        cfg_write(2'd3, 32'h0000_1234);
        cfg_read(2'd1, rd); check("src_align", rd, 32'h0000_0100);
        cfg_read(2'd2, rd); check("dst_align", rd, 32'hABCD_EF04);
        cfg_read(2'd3, rd); check("len_rdbk", rd, 32'h0000_1234);

        for (int v = 0; v < 5; v++) begin
            setup_and_start(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].delay);
            wait_irq($sformatf("vec%0d", v), 1000);
            check_transfer($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
                           vecs[v].exp_beats, vecs[v].exp_last_wr);
            if (vecs[v].len == 16'd0) begin
                check("len0_irq_delay", 32'(irq_time - wr_time), 32'd20);
            end
        end

        // LEN and START writes while busy are ignored.
        setup_and_start(32'h0000_4000, 32'h0000_5000, 16'd5, 2);
        repeat (3) @(negedge clk);
        cfg_read(2'd0, rd);
        check("busy_status", rd, 32'h1);
        cfg_write(2'd3, 32'd99);
        cfg_write(2'd0, 32'd1);
        wait_irq("busy", 1000);
        check_transfer("busy", 32'h0000_4000, 32'h0000_5000, 16'd5, 10, 32'h0000_5010);
        cfg_read(2'd3, rd);
        check("busy_len_kept", rd, 32'd5);
        repeat (20) @(negedge clk);
        check("busy_no_restart", 32'(log_q.size()), 32'd10);

        // Reset while the second read beat is waiting for ack.
        setup_and_start(32'h0000_6000, 32'h0000_7000, 16'd6, 3);
        n = 0;
        while (!(log_q.size() == 1 && dif.dma_stb_o === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach_beat2", 32'(log_q.size() == 1 && dif.dma_stb_o === 1'b1), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_stb", 32'(dif.dma_stb_o), 32'd0);
        check("rst_mid_cyc", 32'(dif.dma_cyc_o), 32'd0);
        cfg_read(2'd1, rd); check("rst_mid_src", rd, 32'h0);
        cfg_read(2'd3, rd); check("rst_mid_len", rd, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_read(2'd0, rd);
        check("rst_mid_status", rd, 32'h0);

        // Clean restart with source address wrapping past 2^32.
        setup_and_start(32'hFFFF_FFF8, 32'h0000_8000, 16'd3, 0);
        wait_irq("wrap", 1000);
        check_transfer("wrap", 32'hFFFF_FFF8, 32'h0000_8000, 16'd3, 6, 32'h0000_8008);
        check("wrap_third_rd_adr", (log_q.size() > 2) ? log_q[2].adr : 32'hDEAD_BEEF, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
